// File: rtl/dpram_fifo_pkg.sv
// rtl/dpram_fifo_pkg.sv - shared defaults and output-buffer state encoding for the DPRAM stream FIFO
// Contents: size defaults (address/data width, depth, almost-full threshold) and the
// 2-entry output buffer occupancy encoding, whose value equals the number of words held.
package dpram_fifo_pkg;

  localparam int AWIDTH_DEF    = 12;
  localparam int NUM_WORDS_DEF = 4096;
  localparam int DWIDTH_DEF    = 40;
  localparam int AF_THRESH_DEF = 4064;

  typedef logic [1:0] buf_state_t;

  localparam buf_state_t BUF_EMPTY = 2'd0;
  localparam buf_state_t BUF_ONE   = 2'd1;
  localparam buf_state_t BUF_TWO   = 2'd2;

endpackage

// File: rtl/dpram_stream_fifo_ctrl_if.sv
// rtl/dpram_stream_fifo_ctrl_if.sv - upstream/downstream valid/ready stream bundle for the DPRAM FIFO
// Signals: in_valid/in_ready/in_data (producer -> FIFO), out_valid/out_ready/out_data (FIFO -> consumer).
// Modports: slave = the FIFO, master = the producer/consumer environment.
interface dpram_stream_fifo_ctrl_if
  import dpram_fifo_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/dpram_4096_40bit.sv
// rtl/dpram_4096_40bit.sv - true dual-port RAM, registered read on port B
// Ports: clock; port A wren_a/address_a/data_a; port B wren_b/address_b/data_b/out_b.
// out_b shows mem[address_b] one cycle after the address is presented. Contents are not reset.
module dpram_4096_40bit #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 40
) (
  input  logic              clock,
  input  logic              wren_a,
  input  logic [AWIDTH-1:0] address_a,
  input  logic [DWIDTH-1:0] data_a,
  input  logic              wren_b,
  input  logic [AWIDTH-1:0] address_b,
  input  logic [DWIDTH-1:0] data_b,
  output logic [DWIDTH-1:0] out_b
);

  logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

  always_ff @(posedge clock) begin
    if (wren_a) mem[address_a] <= data_a;
    if (wren_b) mem[address_b] <= data_b;
    out_b <= mem[address_b];
  end

endmodule

// File: rtl/dpram_fifo_outbuf.sv
// rtl/dpram_fifo_outbuf.sv - 2-entry registered output buffer with valid/ready
// Ports: clk, resetn (async, active low); fill_valid/fill_data (word returning from RAM);
// out_ready in; out_valid/out_data out (registered head); buf_state = occupancy (BUF_*).
// The caller guarantees fill_valid never arrives when both entries are held and no pop occurs.
module dpram_fifo_outbuf
  import dpram_fifo_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fill_valid,
  input  logic [DWIDTH-1:0] fill_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output buf_state_t        buf_state
);

  logic              head_valid;
  logic              tail_valid;
  logic [DWIDTH-1:0] head_data;
  logic [DWIDTH-1:0] tail_data;
  logic              pop;

  assign pop       = head_valid & out_ready;
  assign out_valid = head_valid;
  assign out_data  = head_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_valid <= 1'b0;
      tail_valid <= 1'b0;
      head_data  <= '0;
      tail_data  <= '0;
    end else if (pop) begin
      if (tail_valid) begin
        // Tail moves up; an arriving word refills the tail.
        head_data  <= tail_data;
        tail_valid <= fill_valid;
        if (fill_valid) tail_data <= fill_data;
      end else begin
        head_valid <= fill_valid;
        if (fill_valid) head_data <= fill_data;
      end
    end else if (fill_valid) begin
      if (head_valid) begin
        tail_valid <= 1'b1;
        tail_data  <= fill_data;
      end else begin
        head_valid <= 1'b1;
        head_data  <= fill_data;
      end
    end
  end

  always_comb begin
    buf_state = BUF_EMPTY;
    if (tail_valid)      buf_state = BUF_TWO;
    else if (head_valid) buf_state = BUF_ONE;
  end

endmodule

// File: rtl/dpram_stream_fifo_ctrl.sv
// rtl/dpram_stream_fifo_ctrl.sv - valid/ready stream FIFO around dpram_4096_40bit with read prefetch
// Ports: clk; resetn (async, active low); fifo (dpram_stream_fifo_ctrl_if.slave: in_* upstream,
// out_* downstream); level = words held (RAM + in-flight read + buffer); almost_full = level >= AF_THRESH;
// empty = level == 0.
// Option macro DPRAM_FIFO_PEAK_EN: adds peak_clr (sync clear) and peak_level (max level since reset/clear).
module dpram_stream_fifo_ctrl
  import dpram_fifo_pkg::*;
#(
  parameter int AWIDTH    = AWIDTH_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int AF_THRESH = AF_THRESH_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  dpram_stream_fifo_ctrl_if.slave fifo,
  output logic [AWIDTH:0]         level,
  output logic                    almost_full,
  output logic                    empty
`ifdef DPRAM_FIFO_PEAK_EN
  ,
  input  logic                    peak_clr,
  output logic [AWIDTH:0]         peak_level
`endif
);

  localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH+1)'(NUM_WORDS);
  localparam logic [AWIDTH:0] AF_LEVEL = (AWIDTH+1)'(AF_THRESH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AWIDTH:0]   wr_ptr;
  logic [AWIDTH:0]   rd_ptr;
  logic [AWIDTH:0]   ram_cnt;
  logic              rd_pend;
  logic              push;
  logic              pop;
  logic              rd_issue;
  logic [2:0]        occ;
  logic [DWIDTH-1:0] ram_q;
  logic              ob_valid;
  logic [DWIDTH-1:0] ob_data;
  buf_state_t        buf_state;

  assign ram_cnt       = wr_ptr - rd_ptr;
  assign fifo.in_ready = (ram_cnt != FULL_CNT);
  assign push          = fifo.in_valid & fifo.in_ready;
  assign pop           = ob_valid & fifo.out_ready;

  // Buffer slots committed after this edge: held words plus the word landing now, minus a pop.
  // Counting the pop keeps the prefetch running every cycle under sustained draining.
  assign occ      = {1'b0, buf_state} + {2'b00, rd_pend} - {2'b00, pop};
  assign rd_issue = (ram_cnt != '0) && (occ < 3'd2);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      rd_pend <= rd_issue;
    end
  end

  dpram_4096_40bit #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_ram (
    .clock     (clk),
    .wren_a    (push),
    .address_a (wr_ptr[AWIDTH-1:0]),
    .data_a    (fifo.in_data),
    .wren_b    (1'b0),
    .address_b (rd_ptr[AWIDTH-1:0]),
    .data_b    ({DWIDTH{1'b0}}),
    .out_b     (ram_q)
  );

  dpram_fifo_outbuf #(
    .DWIDTH (DWIDTH)
  ) u_outbuf (
    .clk        (clk),
    .resetn     (resetn),
    .fill_valid (rd_pend),
    .fill_data  (ram_q),
    .out_ready  (fifo.out_ready),
    .out_valid  (ob_valid),
    .out_data   (ob_data),
    .buf_state  (buf_state)
  );

  assign fifo.out_valid = ob_valid;
  assign fifo.out_data  = ob_data;

  assign level       = ram_cnt + (AWIDTH+1)'(rd_pend) + (AWIDTH+1)'(buf_state);
  assign empty       = (level == '0);
  assign almost_full = (level >= AF_LEVEL);

`ifdef DPRAM_FIFO_PEAK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      peak_level <= '0;
    end else if (peak_clr) begin
      peak_level <= '0;
    end else if (level > peak_level) begin
      peak_level <= level;
    end
  end
`endif

endmodule

// File: tb/tb_dpram_stream_fifo_ctrl.sv
// tb/tb_dpram_stream_fifo_ctrl.sv - scoreboard bench for dpram_stream_fifo_ctrl
`timescale 1ns/1ps
module tb_dpram_stream_fifo_ctrl;
  import dpram_fifo_pkg::*;

  localparam int AW  = AWIDTH_DEF;
  localparam int NW  = NUM_WORDS_DEF;
  localparam int DW  = DWIDTH_DEF;
  localparam int AFT = AF_THRESH_DEF;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  dpram_stream_fifo_ctrl_if #(.DWIDTH(DW)) bus ();

  logic [AW:0] level;
  logic        almost_full;
  logic        empty;
`ifdef DPRAM_FIFO_PEAK_EN
  logic        peak_clr = 1'b0;
  logic [AW:0] peak_level;
`endif

  dpram_stream_fifo_ctrl #(
    .AWIDTH    (AW),
    .NUM_WORDS (NW),
    .DWIDTH    (DW),
    .AF_THRESH (AFT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .fifo        (bus),
    .level       (level),
    .almost_full (almost_full),
    .empty       (empty)
`ifdef DPRAM_FIFO_PEAK_EN
    ,
    .peak_clr    (peak_clr),
    .peak_level  (peak_level)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Monitor: records accepted words, checks popped words in order and hold stability.
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d = '0;
  always @(negedge clk) begin
    if (!resetn) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_data", 64'(bus.out_data), 64'(hold_d));
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected actual=%0h expected=none", bus.out_data);
        end else begin
          chk("pop_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
        end
      end
      hold_v = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && t < 200) begin
      step();
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=in_ready0 expected=in_ready1");
      bus.in_valid = 1'b0;
    end else begin
      step();
    end
  endtask

  task automatic in_idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 6000) begin
      step();
      t++;
    end
    if (t >= 6000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_left expected=0", exp_q.size());
    end
    chk("drain_level", 64'(level), 64'd0);
    chk("drain_empty", 64'(empty), 64'd1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int stalls;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_af", 64'(almost_full), 64'd0);
    do_reset();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // 1: single word latency
    bus.out_ready = 1'b1;
    push_word(40'hA5A5A5A5A5);
    in_idle();
    chk("lat_e0", 64'(bus.out_valid), 64'd0);
    step();
    chk("lat_e1", 64'(bus.out_valid), 64'd0);
    step();
    chk("lat_e2_valid", 64'(bus.out_valid), 64'd1);
    chk("lat_e2_data", 64'(bus.out_data), 64'hA5A5A5A5A5);
    step();
    chk("lat_level", 64'(level), 64'd0);
    chk("lat_empty", 64'(empty), 64'd1);

    // 2: fill to full with the consumer stalled, then drain in order
    bus.out_ready = 1'b0;
    for (int n = 0; n < NW + 2; n++) begin
      push_word(40'(n));
      if (n + 1 == AFT - 1) chk("af_below", 64'(almost_full), 64'd0);
      if (n + 1 == AFT)     chk("af_at", 64'(almost_full), 64'd1);
      if (n + 1 == NW) begin
        chk("full_level_4096", 64'(level), 64'(NW));
        chk("full_ready_4096", 64'(bus.in_ready), 64'd1);
      end
    end
    in_idle();
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_level", 64'(level), 64'(NW + 2));
    chk("full_af", 64'(almost_full), 64'd1);
    drain();

    // 3: sustained streaming across pointer wraps
    bus.out_ready = 1'b1;
    stalls = 0;
    for (int i = 0; i < 10000; i++) begin
      push_word(40'h1000000000 + 40'(i));
      if (i >= 2 && !bus.out_valid) stalls++;
    end
    in_idle();
    chk("stream_stalls", 64'(stalls), 64'd0);
    drain();

    // 4: random valid and backpressure
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = {8'hC3, 32'($urandom)};
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_idle();
    drain();

    // 5: asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    for (int i = 0; i < 37; i++) push_word(40'h7700000000 + 40'(i));
    in_idle();
    repeat (3) step();
    chk("mid_level", 64'(level), 64'd37);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("async_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_out_data", 64'(bus.out_data), 64'd0);
    chk("async_level", 64'(level), 64'd0);
    chk("async_empty", 64'(empty), 64'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step();
    chk("post_rst_level", 64'(level), 64'd0);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_word(40'h00C0FFEE00 + 40'(i));
    in_idle();
    drain();

`ifdef DPRAM_FIFO_PEAK_EN
    // 6: peak level tracking and clear
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 100; i++) push_word(40'h2200000000 + 40'(i));
    in_idle();
    repeat (3) step();
    drain();
    chk("peak_before_clr", 64'(peak_level), 64'd100);
    peak_clr = 1'b1;
    step();
    peak_clr = 1'b0;
    chk("peak_after_clr", 64'(peak_level), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
